icache_refill_arbiter: RTL and testbench
========================================

ICACHE_REFILL_ARBITER -- requirements
Module: icache_refill_arbiter

Interface
REQ-001 Parameter PADDR_BITS, default 32, physical address width.
REQ-002 Parameter BLOCK_OFF_BITS, default 6, log2 cache block bytes (64 B block).
REQ-003 Parameter BEAT_BYTES, default 16, TileLink D beat width in bytes (4 beats per block).
REQ-004 clock  in  1  single clock; all state updates on posedge clock.
REQ-005 reset  in  1  reset is asynchronous and active-high.
REQ-006 dmd_valid/dmd_ready  in/out  1/1  demand-miss request handshake.
REQ-007 dmd_addr  in  PADDR_BITS  demand-miss physical address.
REQ-008 dmd_kill  in  1  cancel a demand request not yet issued on A.
REQ-009 pf_valid/pf_ready  in/out  1/1  prefetch request handshake.
REQ-010 pf_addr  in  PADDR_BITS  prefetch physical address.
REQ-011 invalidate  in  1  cache flush; data of the in-flight refill must not be installed.
REQ-012 a_valid/a_ready  out/in  1/1  TileLink A Get handshake.
REQ-013 a_address  out  PADDR_BITS  block-aligned Get address.
REQ-014 d_valid  in  1  TileLink D beat valid; d_ready out 1, tied high.
REQ-015 d_opcode/d_size  in  3/4  D opcode (bit0 = carries data) and log2 transfer size.
REQ-016 refill_owner  out  1  0 = demand, 1 = prefetch owns current refill.
REQ-017 refill_addr  out  PADDR_BITS  block-aligned address of current refill.
REQ-018 beat_wen  out  1  D data beat to be written into data array this cycle.
REQ-019 beat_cnt  out  2  index of current beat within block.
REQ-020 refill_done  out  1  one-cycle pulse on last D beat.
REQ-021 refill_install  out  1  with refill_done: 1 = tag/valid may be written, 0 = discard.
REQ-022 busy  out  1  high in any state other than IDLE.

Function
REQ-023 FSM states IDLE, ISSUE, REFILL; exactly one refill outstanding at any time.
REQ-024 IDLE: dmd_ready = 1, pf_ready = !dmd_valid; in ISSUE/REFILL both readies = 0.
REQ-025 Arbitration: demand has fixed priority over prefetch; a simultaneous pf request is not accepted and stays pending at its source.
REQ-026 On accept, IDLE->ISSUE next cycle; latch refill_addr = addr with low BLOCK_OFF_BITS zeroed; set refill_owner.
REQ-027 ISSUE: a_valid = 1, a_address = refill_addr; a_valid and a_address stable until a_ready.
REQ-028 ISSUE with a_valid && a_ready -> REFILL next cycle.
REQ-029 ISSUE with refill_owner = 0, dmd_kill = 1 and a_ready = 0 -> IDLE next cycle, no A fire; if a_ready = 1 same cycle, the fire wins and kill is ignored.
REQ-030 REFILL: beats = d_opcode[0] ? 2^d_size / BEAT_BYTES : 1; beat counter counts accepted D beats modulo beats, starting at 0.
REQ-031 beat_wen = d_valid && d_opcode[0] && state == REFILL && !invalidated; beat_cnt = beat counter value.
REQ-032 Last beat (counter == beats-1, or beats == 1) with d_valid: refill_done = 1 for that cycle, REFILL -> IDLE next cycle, counter -> 0.
REQ-033 invalidated flag: set by invalidate in ISSUE or REFILL; cleared on entry to IDLE; invalidate in IDLE has no effect on this block.
REQ-034 refill_install = refill_done && !invalidated && !invalidate (same-cycle invalidate also discards).
REQ-035 d_valid outside REFILL is ignored: no beat_wen, no counter change.
REQ-036 Outputs a_valid, beat_wen, refill_done, refill_install combinational from registered state and current inputs; no combinational path from dmd_valid/pf_valid to a_valid.
REQ-037 Back-to-back: a new request may be accepted in the first IDLE cycle after refill_done (minimum 1 idle cycle between refills).

Reset
REQ-038 During/after reset: state IDLE, counter 0, invalidated 0, refill_owner 0, refill_addr 0; a_valid, beat_wen, refill_done, refill_install, busy = 0; dmd_ready = 1.
REQ-039 Reset asserted mid-ISSUE or mid-REFILL aborts immediately to IDLE; subsequent stray D beats are ignored per REQ-035.

Verification
REQ-040 dmd_addr 0x8000_1234 accepted, a_ready held 0 for 3 cycles -> a_valid high 3+1 cycles, a_address 0x8000_1200; 4 beats size 6 -> beat_cnt 0,1,2,3, refill_done+refill_install on beat 3.
REQ-041 dmd_valid and pf_valid same cycle -> dmd accepted, refill_owner 0, pf_ready 0; pf accepted first IDLE cycle after refill_done, refill_owner 1.
REQ-042 invalidate pulse during beat 1 -> beat_wen 0 on beats 2,3; refill_done 1 with refill_install 0; next refill installs normally.
REQ-043 dmd_kill in ISSUE with a_ready 0 -> no A fire, IDLE next cycle, busy 0; dmd_kill with a_ready 1 -> fire proceeds to REFILL.
REQ-044 d_opcode[0] = 0 single beat -> refill_done in that cycle, beat_wen 0.
REQ-045 reset asserted after beat 1 -> all outputs 0 immediately; following d_valid beats produce no beat_wen/refill_done.

Source files
------------

// File: rtl/icache_refill_arbiter.sv
// I-cache refill arbiter: demand/prefetch miss arbitration, one TileLink Get outstanding,
// D-beat sequencing and install/discard decision when the block is flushed mid-refill.
module icache_refill_arbiter #(
  parameter int unsigned PADDR_BITS     = 32,
  parameter int unsigned BLOCK_OFF_BITS = 6,
  parameter int unsigned BEAT_BYTES     = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_dmd_valid,
  output logic                  o_dmd_ready,
  input  logic [PADDR_BITS-1:0] i_dmd_addr,
  input  logic                  i_dmd_kill,
  input  logic                  i_pf_valid,
  output logic                  o_pf_ready,
  input  logic [PADDR_BITS-1:0] i_pf_addr,
  input  logic                  i_invalidate,
  output logic                  o_a_valid,
  input  logic                  i_a_ready,
  output logic [PADDR_BITS-1:0] o_a_address,
  input  logic                  i_d_valid,
  output logic                  o_d_ready,
  input  logic [2:0]            i_d_opcode,
  input  logic [3:0]            i_d_size,
  output logic                  o_refill_owner,
  output logic [PADDR_BITS-1:0] o_refill_addr,
  output logic                  o_beat_wen,
  output logic [1:0]            o_beat_cnt,
  output logic                  o_refill_done,
  output logic                  o_refill_install,
  output logic                  o_busy
);

  localparam int unsigned BeatLg = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {StIdle, StIssue, StRefill} state_e;

  state_e                r_state;
  logic [1:0]            r_cnt;
  logic                  r_inval;
  logic                  r_owner;
  logic [PADDR_BITS-1:0] r_addr;

  logic [PADDR_BITS-1:0] w_dmd_blk;
  logic [PADDR_BITS-1:0] w_pf_blk;
  logic [15:0]           w_beats_m1;
  logic                  w_last;
  logic                  w_dfire;

  assign w_dmd_blk = {i_dmd_addr[PADDR_BITS-1:BLOCK_OFF_BITS], {BLOCK_OFF_BITS{1'b0}}};
  assign w_pf_blk  = {i_pf_addr[PADDR_BITS-1:BLOCK_OFF_BITS], {BLOCK_OFF_BITS{1'b0}}};

  // Dataless responses and transfers no wider than one beat complete in a single beat.
  always_comb begin
    w_beats_m1 = '0;
    if (i_d_opcode[0] && (i_d_size >= 4'(BeatLg))) begin
      w_beats_m1 = (16'd1 << (i_d_size - 4'(BeatLg))) - 16'd1;
    end
  end

  assign w_last  = ({14'd0, r_cnt} == w_beats_m1);
  assign w_dfire = (r_state == StRefill) && i_d_valid;

  assign o_dmd_ready      = (r_state == StIdle);
  assign o_pf_ready       = (r_state == StIdle) && !i_dmd_valid;
  assign o_a_valid        = (r_state == StIssue);
  assign o_a_address      = r_addr;
  assign o_d_ready        = 1'b1;
  assign o_refill_owner   = r_owner;
  assign o_refill_addr    = r_addr;
  assign o_beat_cnt       = r_cnt;
  assign o_beat_wen       = w_dfire && i_d_opcode[0] && !r_inval;
  assign o_refill_done    = w_dfire && w_last;
  assign o_refill_install = o_refill_done && !r_inval && !i_invalidate;
  assign o_busy           = (r_state != StIdle);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
      r_inval <= 1'b0;
      r_owner <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_inval <= 1'b0;
          r_cnt   <= 2'd0;
          if (i_dmd_valid) begin
            r_state <= StIssue;
            r_owner <= 1'b0;
            r_addr  <= w_dmd_blk;
          end else if (i_pf_valid) begin
            r_state <= StIssue;
            r_owner <= 1'b1;
            r_addr  <= w_pf_blk;
          end
        end
        StIssue: begin
          if (i_invalidate) r_inval <= 1'b1;
          // A fire takes precedence over a same-cycle kill.
          if (i_a_ready) begin
            r_state <= StRefill;
          end else if (!r_owner && i_dmd_kill) begin
            r_state <= StIdle;
            r_inval <= 1'b0;
          end
        end
        StRefill: begin
          if (i_invalidate) r_inval <= 1'b1;
          if (i_d_valid) begin
            if (w_last) begin
              r_state <= StIdle;
              r_cnt   <= 2'd0;
              r_inval <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Scoreboard bench for icache_refill_arbiter: a transaction driver predicts A fires, written
// beats and refill completions into queues; a negedge monitor pops and compares them.
module tb_icache_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmd_valid, dmd_kill, pf_valid, invalidate, a_ready, d_valid;
  logic [31:0] dmd_addr, pf_addr;
  logic [2:0]  d_opcode;
  logic [3:0]  d_size;
  logic        dmd_ready, pf_ready, a_valid, d_ready, refill_owner;
  logic        beat_wen, refill_done, refill_install, busy;
  logic [31:0] a_address, refill_addr;
  logic [1:0]  beat_cnt;

  icache_refill_arbiter dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_dmd_valid      (dmd_valid),
    .o_dmd_ready      (dmd_ready),
    .i_dmd_addr       (dmd_addr),
    .i_dmd_kill       (dmd_kill),
    .i_pf_valid       (pf_valid),
    .o_pf_ready       (pf_ready),
    .i_pf_addr        (pf_addr),
    .i_invalidate     (invalidate),
    .o_a_valid        (a_valid),
    .i_a_ready        (a_ready),
    .o_a_address      (a_address),
    .i_d_valid        (d_valid),
    .o_d_ready        (d_ready),
    .i_d_opcode       (d_opcode),
    .i_d_size         (d_size),
    .o_refill_owner   (refill_owner),
    .o_refill_addr    (refill_addr),
    .o_beat_wen       (beat_wen),
    .o_beat_cnt       (beat_cnt),
    .o_refill_done    (refill_done),
    .o_refill_install (refill_install),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          install;
    bit          owner;
    logic [31:0] blk;
  } done_t;

  logic [31:0] q_a[$];
  int          q_beat[$];
  done_t       q_done[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  always @(negedge clk) begin
    if (a_valid && a_ready) begin
      if (q_a.size() == 0) unexpected("a_fire");
      else chk("a_fire_address", a_address, q_a.pop_front());
    end
    if (beat_wen) begin
      if (q_beat.size() == 0) unexpected("beat_wen");
      else chk("beat_cnt", 32'(beat_cnt), q_beat.pop_front());
    end
    if (refill_done) begin
      if (q_done.size() == 0) unexpected("refill_done");
      else begin
        done_t e;
        e = q_done.pop_front();
        chk("refill_install", 32'(refill_install), 32'(e.install));
        chk("done_owner", 32'(refill_owner), 32'(e.owner));
        chk("done_addr", refill_addr, e.blk);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_beat_wen", 32'(beat_wen), 0);
    chk("rst_done", 32'(refill_done), 0);
    chk("rst_install", 32'(refill_install), 0);
    chk("rst_owner", 32'(refill_owner), 0);
    chk("rst_refill_addr", refill_addr, 0);
    chk("rst_dmd_ready", 32'(dmd_ready), 1);
  endtask

  // Idle cycles carrying stray D beats and invalidates, both of which must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      invalidate = 1'($urandom_range(0, 1));
      d_valid    = 1'($urandom_range(0, 1));
      d_opcode   = 3'd1;
      d_size     = 4'd6;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      step();
      invalidate = 1'b0;
      d_valid    = 1'b0;
    end
  endtask

  // kill_mode: 0 none, 1 kill while a_ready low on first ISSUE cycle, 2 kill on the fire cycle.
  // inval_at: -1 none, -2 during ISSUE, else beat index. rst_after: beat index, -1 none.
  task automatic do_refill(input bit pf, input logic [31:0] addr, input int adelay,
                           input int kill_mode, input bit op0, input int size,
                           input int inval_at, input int rst_after);
    logic [31:0] blk;
    bit          aborted;
    bit          inv;
    int          nbeats;
    blk     = (addr / 32'd64) * 32'd64;
    aborted = (kill_mode == 1) && !pf;
    nbeats  = op0 ? (1 << size) / 16 : 1;
    if (nbeats < 1) nbeats = 1;
    if (pf) begin
      pf_valid = 1'b1;
      pf_addr  = addr;
    end else begin
      dmd_valid = 1'b1;
      dmd_addr  = addr;
    end
    @(negedge clk);
    chk("req_busy", 32'(busy), 0);
    chk("req_a_valid", 32'(a_valid), 0);
    chk("req_dmd_ready", 32'(dmd_ready), 1);
    chk("req_pf_ready", 32'(pf_ready), 32'(!dmd_valid));
    if (!aborted) q_a.push_back(blk);
    step();
    dmd_valid = 1'b0;
    if (pf) pf_valid = 1'b0;
    inv = (inval_at == -2);
    for (int c = 0; c <= adelay; c++) begin
      a_ready    = (c == adelay);
      dmd_kill   = (kill_mode == 1 && c == 0) || (kill_mode == 2 && c == adelay);
      invalidate = (inval_at == -2 && c == 0);
      @(negedge clk);
      chk("issue_a_valid", 32'(a_valid), 1);
      chk("issue_a_address", a_address, blk);
      chk("issue_owner", 32'(refill_owner), 32'(pf));
      chk("issue_dmd_ready", 32'(dmd_ready), 0);
      chk("issue_pf_ready", 32'(pf_ready), 0);
      step();
      a_ready    = 1'b0;
      dmd_kill   = 1'b0;
      invalidate = 1'b0;
      if (aborted) return;
    end
    for (int b = 0; b < nbeats; b++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("refill_busy", 32'(busy), 1);
        step();
      end
      d_valid    = 1'b1;
      d_opcode   = {2'($urandom_range(0, 3)), op0};
      d_size     = 4'(size);
      invalidate = (inval_at == b);
      if (op0 && !inv) q_beat.push_back(b);
      if (b == nbeats - 1) q_done.push_back('{!inv && (inval_at != b), pf, blk});
      if (inval_at == b) inv = 1'b1;
      @(negedge clk);
      chk("beat_a_valid", 32'(a_valid), 0);
      step();
      d_valid    = 1'b0;
      invalidate = 1'b0;
      if (rst_after == b) begin
        rst       = 1'b1;
        pf_valid  = 1'b0;
        #1;
        chk_reset_outputs();
        step();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
          d_valid  = 1'b1;
          d_opcode = 3'd1;
          d_size   = 4'd6;
          @(negedge clk);
          chk("post_rst_busy", 32'(busy), 0);
          step();
        end
        d_valid = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    {dmd_valid, dmd_kill, pf_valid, invalidate, a_ready, d_valid} = '0;
    dmd_addr = '0;
    pf_addr  = '0;
    d_opcode = '0;
    d_size   = '0;
    step();
    chk_reset_outputs();
    chk("rst_d_ready", 32'(d_ready), 1);
    step();
    rst = 1'b0;

    // Demand miss, A stalled 3 cycles, 4-beat refill.
    do_refill(1'b0, 32'h8000_1234, 3, 0, 1'b1, 6, -1, -1);
    // Simultaneous demand/prefetch: demand wins, prefetch taken right after done.
    pf_valid = 1'b1;
    pf_addr  = 32'h1234_5678;
    do_refill(1'b0, 32'h0000_0fc0, 1, 0, 1'b1, 6, -1, -1);
    do_refill(1'b1, 32'h1234_5678, 0, 0, 1'b1, 6, -1, -1);
    // Invalidate on beat 1 discards the block; the next refill installs.
    do_refill(1'b0, 32'h4000_0040, 0, 0, 1'b1, 6, 1, -1);
    do_refill(1'b0, 32'h4000_0080, 0, 0, 1'b1, 6, -1, -1);
    // Kill while stalled aborts; kill on the fire cycle is ignored.
    do_refill(1'b0, 32'h2000_0000, 2, 1, 1'b1, 6, -1, -1);
    do_refill(1'b0, 32'h2000_0100, 0, 2, 1'b1, 6, -1, -1);
    // Dataless single-beat response.
    do_refill(1'b0, 32'h3000_0010, 0, 0, 1'b0, 6, -1, -1);
    // Reset after beat 1, stray beats afterwards.
    do_refill(1'b0, 32'h5000_0000, 0, 0, 1'b1, 6, -1, 1);
    do_refill(1'b1, 32'h5000_0400, 1, 0, 1'b1, 6, -1, -1);

    for (int t = 0; t < 150; t++) begin
      bit          pf, both, op0;
      logic [31:0] addr, paddr;
      int          ad, km, sz, nb, r, inv, rs;
      pf    = ($urandom_range(0, 3) == 0);
      both  = !pf && ($urandom_range(0, 4) == 0);
      addr  = $urandom;
      paddr = $urandom;
      ad    = $urandom_range(0, 3);
      km    = $urandom_range(0, 5);
      km    = (km == 0) ? 1 : (km == 1) ? 2 : 0;
      if (km == 1 && ad == 0) ad = 1;
      op0   = ($urandom_range(0, 4) != 0);
      sz    = $urandom_range(4, 6);
      nb    = op0 ? (1 << sz) / 16 : 1;
      r     = $urandom_range(0, 9);
      inv   = (r == 0) ? -2 : (r < 3) ? $urandom_range(0, nb - 1) : -1;
      rs    = (nb > 1 && $urandom_range(0, 14) == 0) ? $urandom_range(0, nb - 2) : -1;
      if (both) begin
        pf_valid = 1'b1;
        pf_addr  = paddr;
      end
      do_refill(pf, addr, ad, km, op0, sz, inv, rs);
      if (both) do_refill(1'b1, paddr, $urandom_range(0, 2), 0, 1'b1, 6, -1, -1);
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(2);
    chk("a_queue_drained", 32'(q_a.size()), 0);
    chk("beat_queue_drained", 32'(q_beat.size()), 0);
    chk("done_queue_drained", 32'(q_done.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
